// File: rtl/llr_magnitude_minfind_seq_if.sv
// Beat/result bundle for llr_magnitude_minfind_seq.
// master: the producer of LLR beats that also consumes the codeword results.
// slave : the magnitude / min-find block itself.
interface llr_magnitude_minfind_seq_if #(
  parameter int LLR_LEN     = 4,
  parameter int PARALLELISM = 1,
  parameter int CODE_LEN    = 255,
  parameter int NUM_MIN     = 2
);
  localparam int MAG_LEN = LLR_LEN - 1;
  localparam int IDX_LEN = $clog2(CODE_LEN);

  logic                           in_ctr_en;
  logic                           in_ctr_init;
  logic                           in_ctr_done;
  logic [LLR_LEN*PARALLELISM-1:0] in_llr;
  logic [MAG_LEN*PARALLELISM-1:0] out_llr_mag;
  logic [PARALLELISM-1:0]         out_hd;
  logic                           out_parity;
  logic [MAG_LEN*NUM_MIN-1:0]     out_min_mag;
  logic [IDX_LEN*NUM_MIN-1:0]     out_min_idx;
  logic                           out_valid;

  modport master (
    output in_ctr_en, in_ctr_init, in_ctr_done, in_llr,
    input  out_llr_mag, out_hd, out_parity, out_min_mag, out_min_idx, out_valid
  );

  modport slave (
    input  in_ctr_en, in_ctr_init, in_ctr_done, in_llr,
    output out_llr_mag, out_hd, out_parity, out_min_mag, out_min_idx, out_valid
  );
endinterface

// File: rtl/llr_magnitude_minfind_seq.sv
// LLR to saturated magnitude / hard decision, with per-codeword parity and
// a sorted list of the NUM_MIN least-reliable positions.
// Optional macro LLR_MAG_PARITY_EN: when defined the parity accumulator is
// built; otherwise out_parity is tied low.
module llr_magnitude_minfind_seq #(
  parameter int LLR_LEN     = 4,
  parameter int PARALLELISM = 1,
  parameter int CODE_LEN    = 255,
  parameter int NUM_MIN     = 2
) (
  input logic                      clk,
  input logic                      in_ctr_Arst_n,
  llr_magnitude_minfind_seq_if.slave bus
);
  localparam int MAG_LEN = LLR_LEN - 1;
  localparam int IDX_LEN = $clog2(CODE_LEN);
  localparam int NBEATS  = (CODE_LEN + PARALLELISM - 1) / PARALLELISM;
  localparam int CW      = $clog2(NBEATS + 1);
  // wide enough for the largest lane index of a saturated counter
  localparam int BW      = $clog2(NBEATS*PARALLELISM + PARALLELISM);

  logic [MAG_LEN-1:0]             lane_mag [PARALLELISM];
  logic [PARALLELISM-1:0]         lane_hd;
  logic [BW-1:0]                  lane_idx [PARALLELISM];
  logic [PARALLELISM-1:0]         lane_ok;
  logic [BW-1:0]                  base_idx;

  logic [CW-1:0]                  cnt_q;
  logic [MAG_LEN-1:0]             min_mag_q [NUM_MIN];
  logic [IDX_LEN-1:0]             min_idx_q [NUM_MIN];
  logic [NUM_MIN-1:0]             min_vld_q;

  logic [MAG_LEN-1:0]             ins_mag [NUM_MIN];
  logic [IDX_LEN-1:0]             ins_idx [NUM_MIN];
  logic [NUM_MIN-1:0]             ins_vld;
  logic [MAG_LEN-1:0]             c_mag, t_mag;
  logic [IDX_LEN-1:0]             c_idx, t_idx;
  logic                           c_vld, t_vld, shifting;

  logic [MAG_LEN*PARALLELISM-1:0] out_llr_mag_q;
  logic [PARALLELISM-1:0]         out_hd_q;
  logic [MAG_LEN*NUM_MIN-1:0]     out_min_mag_q;
  logic [IDX_LEN*NUM_MIN-1:0]     out_min_idx_q;
  logic                           out_valid_q;

  // per-lane |llr| with the most negative code saturated to all-ones
  always_comb begin
    for (int i = 0; i < PARALLELISM; i++) begin
      lane_hd[i] = bus.in_llr[LLR_LEN*i + MAG_LEN];
      if (!lane_hd[i])
        lane_mag[i] = bus.in_llr[LLR_LEN*i +: MAG_LEN];
      else if (bus.in_llr[LLR_LEN*i +: MAG_LEN] == '0)
        lane_mag[i] = '1;
      else
        lane_mag[i] = ~bus.in_llr[LLR_LEN*i +: MAG_LEN] + 1'b1;
    end
  end

  // bit index of each lane; lanes at or beyond CODE_LEN are padding
  always_comb begin
    base_idx = bus.in_ctr_init ? '0 : BW'(cnt_q) * BW'(PARALLELISM);
    for (int i = 0; i < PARALLELISM; i++) begin
      lane_idx[i] = base_idx + BW'(i);
      lane_ok[i]  = lane_idx[i] < BW'(CODE_LEN);
    end
  end

  // chained sorted insertion of this beat's lanes, lane 0 first; once a
  // candidate lands, every later entry shifts down one slot
  always_comb begin
    c_mag    = '0;
    c_idx    = '0;
    c_vld    = 1'b0;
    t_mag    = '0;
    t_idx    = '0;
    t_vld    = 1'b0;
    shifting = 1'b0;
    for (int j = 0; j < NUM_MIN; j++) begin
      ins_mag[j] = bus.in_ctr_init ? '0 : min_mag_q[j];
      ins_idx[j] = bus.in_ctr_init ? '0 : min_idx_q[j];
      ins_vld[j] = bus.in_ctr_init ? 1'b0 : min_vld_q[j];
    end
    for (int i = 0; i < PARALLELISM; i++) begin
      if (lane_ok[i]) begin
        c_mag    = lane_mag[i];
        c_idx    = IDX_LEN'(lane_idx[i]);
        c_vld    = 1'b1;
        shifting = 1'b0;
        for (int j = 0; j < NUM_MIN; j++) begin
          if (shifting || !ins_vld[j] || (c_mag < ins_mag[j])) begin
            t_mag      = ins_mag[j];
            t_idx      = ins_idx[j];
            t_vld      = ins_vld[j];
            ins_mag[j] = c_mag;
            ins_idx[j] = c_idx;
            ins_vld[j] = c_vld;
            c_mag      = t_mag;
            c_idx      = t_idx;
            c_vld      = t_vld;
            shifting   = 1'b1;
          end
        end
      end
    end
  end

`ifdef LLR_MAG_PARITY_EN
  logic par_q, par_d, out_parity_q;

  // hard-decision parity of the non-padding lanes, restarted on init
  always_comb begin
    par_d = bus.in_ctr_init ? 1'b0 : par_q;
    for (int i = 0; i < PARALLELISM; i++)
      if (lane_ok[i]) par_d = par_d ^ lane_hd[i];
  end

  // parity accumulator and its codeword result register
  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      par_q        <= 1'b0;
      out_parity_q <= 1'b0;
    end else if (bus.in_ctr_en) begin
      par_q <= par_d;
      if (bus.in_ctr_done) out_parity_q <= par_d;
    end
  end

  assign bus.out_parity = out_parity_q;
`else
  assign bus.out_parity = 1'b0;
`endif

  // beat counter, min list, per-beat outputs and codeword result registers
  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      cnt_q         <= '0;
      min_vld_q     <= '0;
      out_llr_mag_q <= '0;
      out_hd_q      <= '0;
      out_min_mag_q <= '0;
      out_min_idx_q <= '0;
      out_valid_q   <= 1'b0;
      for (int j = 0; j < NUM_MIN; j++) begin
        min_mag_q[j] <= '0;
        min_idx_q[j] <= '0;
      end
    end else begin
      out_valid_q <= bus.in_ctr_en & bus.in_ctr_done;
      if (bus.in_ctr_en) begin
        for (int i = 0; i < PARALLELISM; i++)
          out_llr_mag_q[MAG_LEN*i +: MAG_LEN] <= lane_mag[i];
        out_hd_q <= lane_hd;
        if (bus.in_ctr_init)
          cnt_q <= CW'(1);
        else if (cnt_q < CW'(NBEATS))
          cnt_q <= cnt_q + CW'(1);
        min_vld_q <= ins_vld;
        for (int j = 0; j < NUM_MIN; j++) begin
          min_mag_q[j] <= ins_mag[j];
          min_idx_q[j] <= ins_idx[j];
        end
        if (bus.in_ctr_done) begin
          // still-empty slots report all-ones so consumers see "no position"
          for (int j = 0; j < NUM_MIN; j++) begin
            out_min_mag_q[MAG_LEN*j +: MAG_LEN] <= ins_vld[j] ? ins_mag[j] : '1;
            out_min_idx_q[IDX_LEN*j +: IDX_LEN] <= ins_vld[j] ? ins_idx[j] : '1;
          end
        end
      end
    end
  end

  assign bus.out_llr_mag = out_llr_mag_q;
  assign bus.out_hd      = out_hd_q;
  assign bus.out_min_mag = out_min_mag_q;
  assign bus.out_min_idx = out_min_idx_q;
  assign bus.out_valid   = out_valid_q;
endmodule
